alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Holds decoded ALU-class instructions (LUI/AUIPC/JAL/JALR/branches/R-type/I-type) until both source operands are known.
- Snoops the two result broadcast buses (ALU, LSB) to wake waiting operands.
- Each cycle, issues at most one ready entry to the ALU stage.
- Sits between the decoder/dispatch stage and the ALU; flushed by the reorder buffer on mispredict.

Parameters:
- DEPTH, 16, number of entries (power of two)
- IDX_W, 4, log2(DEPTH)
- ROB_ID_W, 4, reorder-buffer tag width
- OP_W, 6, opcode-id width (shared OpId encoding)
- DATA_W, 32, data/address/immediate width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- ID_input_valid  in  1  dispatch request
- ID_OP_ID  in  OP_W  operation id
- ID_inst_pc  in  DATA_W  instruction pc
- ID_Vj, ID_Vk  in  DATA_W each  operand values (meaningful when matching Q not pending)
- ID_Qj_busy, ID_Qk_busy  in  1 each  operand still pending
- ID_Qj, ID_Qk  in  ROB_ID_W each  producer tags
- ID_imm  in  DATA_W  immediate
- ID_ROB_id  in  ROB_ID_W  destination tag
- RS_full  out  1  registered; upstream must not dispatch while high
- ALU_cdb_valid/ALU_cdb_ROB_id/ALU_cdb_value  in  1/ROB_ID_W/DATA_W  ALU broadcast
- LSB_cdb_valid/LSB_cdb_ROB_id/LSB_cdb_value  in  1/ROB_ID_W/DATA_W  load broadcast
- ROB_clear  in  1  mispredict flush
- ALU_output_valid  out  1  issue strobe to ALU
- ALU_OP_ID, ALU_inst_pc, ALU_reg_rs1, ALU_reg_rs2, ALU_imm, ALU_ROB_id  out  as above  issued operands

Behaviour:
- Reset (rst=1 at posedge): all entry busy bits cleared; RS_full=0; ALU_output_valid=0; all other outputs 0. Reset beats rdy and ROB_clear.
- rdy=0: no state change; outputs hold.
- Priority per edge with rdy=1: ROB_clear > {dispatch, wakeup, issue}.
- ROB_clear: all entries freed; ALU_output_valid<=0; RS_full<=0; same-cycle dispatch and broadcasts are dropped.
- Dispatch:
  - Applies when ID_input_valid=1 and RS_full=0. It is ignored if RS_full=1.
  - Writes the lowest-index free entry.
  - A dispatched entry is not issue-eligible on its write edge.
- Wakeup: for every busy entry with Qj_busy and Qj==cdb tag (either bus, valid=1), Vj<=value and Qj_busy<=0; same for k. If both buses match, the ALU bus wins (cannot occur legally).
- Ready: busy and !Qj_busy and !Qk_busy, evaluated on pre-edge state. A value woken at edge t is issuable at edge t+1.
- Issue:
  - Select the lowest-index ready entry; register its fields to the ALU_* outputs; ALU_output_valid<=1; free the entry.
  - If nothing is ready, ALU_output_valid<=0.
  - Throughput is 1/cycle.
  - An entry freed by issue is reusable by dispatch at the next edge, not the same edge.
- Latency: dispatch with ready operands at edge t → ALU_output_valid high after edge t+1.
- RS_full: registered, <=1 when next-state occupancy ≥ DEPTH-1. This guarantees the single dispatch accepted while it was low fits.
- Dispatch with both Q not busy is legal; operands for LUI/AUIPC/JAL are dispatched not-busy.

Optional Feature:
- Macro RS_DISPATCH_FWD_EN.
- Defined: a dispatch whose Qj/Qk matches a same-edge valid broadcast captures the broadcast value and stores the operand as not busy.
- Undefined: the dispatch operands are stored as given; upstream guarantees forwarding. A tag broadcast on the dispatch edge is otherwise lost (documented deadlock hazard).

Decomposition:
- Shared defines package: OpId encodings, DataWidth, ROBIDBus, True/False, DEPTH/IDX_W.
- One sub-module, rs_prio_select: a lowest-index priority encoder with found flag. It is instantiated twice (free-slot search, ready search).

Test Plan:
- Reset then dispatch ADDI rob=3, Vj=5, imm=7, no pending → ALU_output_valid one cycle later with rs1=5, imm=7, ALU_ROB_id=3; then 0.
- Dispatch ADD with Qj=2 busy; LSB broadcast rob=2 value=0x10 two cycles later → issue exactly one cycle after broadcast with rs1=0x10.
- Fill 15 entries with pending operands → RS_full=1; a dispatch attempt is ignored (count unchanged); broadcast wakes one, issue → RS_full=0.
- Three ready entries at indices 0,2,5 → issued in order 0,2,5 on consecutive cycles.
- ROB_clear with 6 busy entries and a simultaneous dispatch → all freed, no issue next cycle, RS_full=0.
- Dispatch BEQ with Qj=4 on the same edge as ALU broadcast rob=4 value=9 → with RS_DISPATCH_FWD_EN: issues next cycle with rs1=9; without it: never issues.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the ALU reservation station: sizes, OpId encodings,
// entry/issue records and the broadcast-match helper.
package alu_reservation_station_pkg;

  localparam int unsigned Depth     = 16;
  localparam int unsigned IdxW      = 4;
  localparam int unsigned RobIdW    = 4;
  localparam int unsigned OpW       = 6;
  localparam int unsigned DataWidth = 32;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef logic [DataWidth-1:0] data_t;
  typedef logic [RobIdW-1:0]    rob_id_t;
  typedef logic [OpW-1:0]       op_id_t;

  // Shared OpId encoding (ALU-class subset).
  typedef enum logic [OpW-1:0] {
    OpNop   = 6'd0,
    OpLui   = 6'd1,
    OpAuipc = 6'd2,
    OpJal   = 6'd3,
    OpJalr  = 6'd4,
    OpBeq   = 6'd5,
    OpBne   = 6'd6,
    OpBlt   = 6'd7,
    OpBge   = 6'd8,
    OpAdd   = 6'd20,
    OpSub   = 6'd21,
    OpAddi  = 6'd30
  } op_e;

  typedef struct packed {
    logic    busy;
    op_id_t  op;
    data_t   pc;
    data_t   vj;
    data_t   vk;
    logic    qj_busy;
    logic    qk_busy;
    rob_id_t qj;
    rob_id_t qk;
    data_t   imm;
    rob_id_t rob;
  } entry_t;

  typedef struct packed {
    logic    valid;
    op_id_t  op;
    data_t   pc;
    data_t   rs1;
    data_t   rs2;
    data_t   imm;
    rob_id_t rob;
  } issue_t;

  function automatic logic cdb_hit(logic valid, rob_id_t tag, rob_id_t q);
    return valid && (tag == q);
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, broadcast, flush and issue signals of the ALU reservation station.
interface alu_reservation_station_if;
  import alu_reservation_station_pkg::*;

  logic    rdy;
  logic    ID_input_valid;
  op_id_t  ID_OP_ID;
  data_t   ID_inst_pc;
  data_t   ID_Vj;
  data_t   ID_Vk;
  logic    ID_Qj_busy;
  logic    ID_Qk_busy;
  rob_id_t ID_Qj;
  rob_id_t ID_Qk;
  data_t   ID_imm;
  rob_id_t ID_ROB_id;
  logic    RS_full;
  logic    ALU_cdb_valid;
  rob_id_t ALU_cdb_ROB_id;
  data_t   ALU_cdb_value;
  logic    LSB_cdb_valid;
  rob_id_t LSB_cdb_ROB_id;
  data_t   LSB_cdb_value;
  logic    ROB_clear;
  logic    ALU_output_valid;
  op_id_t  ALU_OP_ID;
  data_t   ALU_inst_pc;
  data_t   ALU_reg_rs1;
  data_t   ALU_reg_rs2;
  data_t   ALU_imm;
  rob_id_t ALU_ROB_id;

  modport master (
    output rdy, ID_input_valid, ID_OP_ID, ID_inst_pc, ID_Vj, ID_Vk, ID_Qj_busy, ID_Qk_busy,
           ID_Qj, ID_Qk, ID_imm, ID_ROB_id, ALU_cdb_valid, ALU_cdb_ROB_id, ALU_cdb_value,
           LSB_cdb_valid, LSB_cdb_ROB_id, LSB_cdb_value, ROB_clear,
    input  RS_full, ALU_output_valid, ALU_OP_ID, ALU_inst_pc, ALU_reg_rs1, ALU_reg_rs2,
           ALU_imm, ALU_ROB_id
  );

  modport slave (
    input  rdy, ID_input_valid, ID_OP_ID, ID_inst_pc, ID_Vj, ID_Vk, ID_Qj_busy, ID_Qk_busy,
           ID_Qj, ID_Qk, ID_imm, ID_ROB_id, ALU_cdb_valid, ALU_cdb_ROB_id, ALU_cdb_value,
           LSB_cdb_valid, LSB_cdb_ROB_id, LSB_cdb_value, ROB_clear,
    output RS_full, ALU_output_valid, ALU_OP_ID, ALU_inst_pc, ALU_reg_rs1, ALU_reg_rs2,
           ALU_imm, ALU_ROB_id
  );

endinterface

// File: rtl/alu_reservation_station_rs_prio_select.sv
// Lowest-index priority encoder with a found flag.
module rs_prio_select #(
  parameter int unsigned N    = 16,
  parameter int unsigned IdxW = 4
) (
  input  logic [N-1:0]    req_i,
  output logic [IdxW-1:0] idx_o,
  output logic            found_o
);

  // Scan high to low so the lowest set request is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IdxW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ALU-class ops until both operands
// are known, snoops the ALU/LSB broadcast buses and issues one ready op per cycle.
// Optional macro RS_DISPATCH_FWD_EN: a dispatch captures a same-edge broadcast
// for its pending operands instead of losing it.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
(
  input logic                       clk,
  input logic                       rst,
  alu_reservation_station_if.slave  rs_if
);

  localparam logic [IdxW:0] FullMark = (IdxW + 1)'(Depth - 1);

  entry_t [Depth-1:0] entries_q, entries_d;
  issue_t             issue_q, issue_d;
  logic               full_q, full_d;

  logic [Depth-1:0] free_vec, ready_vec;
  logic [IdxW-1:0]  free_idx, ready_idx;
  logic             free_found, ready_found;
  logic [IdxW:0]    occ;
  entry_t           new_entry;

  // Free/ready request vectors from pre-edge state.
  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      free_vec[i]  = !entries_q[i].busy;
      ready_vec[i] = entries_q[i].busy && !entries_q[i].qj_busy && !entries_q[i].qk_busy;
    end
  end

  rs_prio_select #(.N(Depth), .IdxW(IdxW)) u_free_sel (
    .req_i   (free_vec),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  rs_prio_select #(.N(Depth), .IdxW(IdxW)) u_ready_sel (
    .req_i   (ready_vec),
    .idx_o   (ready_idx),
    .found_o (ready_found)
  );

  // Entry image written by a dispatch, optionally forwarding same-edge broadcasts.
  always_comb begin
    new_entry         = '0;
    new_entry.busy    = True;
    new_entry.op      = rs_if.ID_OP_ID;
    new_entry.pc      = rs_if.ID_inst_pc;
    new_entry.vj      = rs_if.ID_Vj;
    new_entry.vk      = rs_if.ID_Vk;
    new_entry.qj_busy = rs_if.ID_Qj_busy;
    new_entry.qk_busy = rs_if.ID_Qk_busy;
    new_entry.qj      = rs_if.ID_Qj;
    new_entry.qk      = rs_if.ID_Qk;
    new_entry.imm     = rs_if.ID_imm;
    new_entry.rob     = rs_if.ID_ROB_id;
`ifdef RS_DISPATCH_FWD_EN
    if (new_entry.qj_busy) begin
      if (cdb_hit(rs_if.ALU_cdb_valid, rs_if.ALU_cdb_ROB_id, new_entry.qj)) begin
        new_entry.vj      = rs_if.ALU_cdb_value;
        new_entry.qj_busy = False;
      end else if (cdb_hit(rs_if.LSB_cdb_valid, rs_if.LSB_cdb_ROB_id, new_entry.qj)) begin
        new_entry.vj      = rs_if.LSB_cdb_value;
        new_entry.qj_busy = False;
      end
    end
    if (new_entry.qk_busy) begin
      if (cdb_hit(rs_if.ALU_cdb_valid, rs_if.ALU_cdb_ROB_id, new_entry.qk)) begin
        new_entry.vk      = rs_if.ALU_cdb_value;
        new_entry.qk_busy = False;
      end else if (cdb_hit(rs_if.LSB_cdb_valid, rs_if.LSB_cdb_ROB_id, new_entry.qk)) begin
        new_entry.vk      = rs_if.LSB_cdb_value;
        new_entry.qk_busy = False;
      end
    end
`endif
  end

  // Next state: flush, else wakeup + issue + dispatch; rdy low holds everything.
  always_comb begin
    entries_d = entries_q;
    issue_d   = issue_q;
    full_d    = full_q;
    occ       = '0;
    if (rs_if.rdy) begin
      if (rs_if.ROB_clear) begin
        for (int i = 0; i < Depth; i++) entries_d[i].busy = False;
        issue_d.valid = False;
        full_d        = False;
      end else begin
        for (int i = 0; i < Depth; i++) begin
          if (entries_q[i].busy && entries_q[i].qj_busy) begin
            if (cdb_hit(rs_if.ALU_cdb_valid, rs_if.ALU_cdb_ROB_id, entries_q[i].qj)) begin
              entries_d[i].vj      = rs_if.ALU_cdb_value;
              entries_d[i].qj_busy = False;
            end else if (cdb_hit(rs_if.LSB_cdb_valid, rs_if.LSB_cdb_ROB_id, entries_q[i].qj)) begin
              entries_d[i].vj      = rs_if.LSB_cdb_value;
              entries_d[i].qj_busy = False;
            end
          end
          if (entries_q[i].busy && entries_q[i].qk_busy) begin
            if (cdb_hit(rs_if.ALU_cdb_valid, rs_if.ALU_cdb_ROB_id, entries_q[i].qk)) begin
              entries_d[i].vk      = rs_if.ALU_cdb_value;
              entries_d[i].qk_busy = False;
            end else if (cdb_hit(rs_if.LSB_cdb_valid, rs_if.LSB_cdb_ROB_id, entries_q[i].qk)) begin
              entries_d[i].vk      = rs_if.LSB_cdb_value;
              entries_d[i].qk_busy = False;
            end
          end
        end
        if (ready_found) begin
          issue_d.valid = True;
          issue_d.op    = entries_q[ready_idx].op;
          issue_d.pc    = entries_q[ready_idx].pc;
          issue_d.rs1   = entries_q[ready_idx].vj;
          issue_d.rs2   = entries_q[ready_idx].vk;
          issue_d.imm   = entries_q[ready_idx].imm;
          issue_d.rob   = entries_q[ready_idx].rob;
          entries_d[ready_idx].busy = False;
        end else begin
          issue_d.valid = False;
        end
        // free_idx comes from pre-edge state, so a slot freed by issue is not reused here.
        if (rs_if.ID_input_valid && !full_q && free_found) begin
          entries_d[free_idx] = new_entry;
        end
        for (int i = 0; i < Depth; i++) occ = occ + (IdxW + 1)'(entries_d[i].busy);
        full_d = (occ >= FullMark);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
      issue_q   <= '0;
      full_q    <= 1'b0;
    end else begin
      entries_q <= entries_d;
      issue_q   <= issue_d;
      full_q    <= full_d;
    end
  end

  assign rs_if.RS_full          = full_q;
  assign rs_if.ALU_output_valid = issue_q.valid;
  assign rs_if.ALU_OP_ID        = issue_q.op;
  assign rs_if.ALU_inst_pc      = issue_q.pc;
  assign rs_if.ALU_reg_rs1      = issue_q.rs1;
  assign rs_if.ALU_reg_rs2      = issue_q.rs2;
  assign rs_if.ALU_imm          = issue_q.imm;
  assign rs_if.ALU_ROB_id       = issue_q.rob;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios then random traffic,
// every cycle compared with a behavioural slot model.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_reservation_station_if rs_if ();

  alu_reservation_station dut (
    .clk   (clk),
    .rst   (rst),
    .rs_if (rs_if)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: a slot table plus the expected output register.
  typedef struct {
    bit      used;
    op_id_t  op;
    data_t   pc, vj, vk, imm;
    bit      jb, kb;
    rob_id_t qj, qk, rob;
  } m_ent_t;

  m_ent_t  m_ent [Depth];
  bit      e_valid, e_full;
  op_id_t  e_op;
  data_t   e_pc, e_rs1, e_rs2, e_imm;
  rob_id_t e_rob;

  function automatic void snoop(inout bit busy, input rob_id_t tag, inout data_t val);
    if (!busy) return;
    if (rs_if.ALU_cdb_valid && rs_if.ALU_cdb_ROB_id == tag) begin
      val = rs_if.ALU_cdb_value; busy = 0;
    end else if (rs_if.LSB_cdb_valid && rs_if.LSB_cdb_ROB_id == tag) begin
      val = rs_if.LSB_cdb_value; busy = 0;
    end
  endfunction

  function automatic void model_step();
    int r = -1;
    int f = -1;
    int n = 0;
    m_ent_t ne;
    if (rst) begin
      foreach (m_ent[i]) m_ent[i].used = 0;
      e_valid = 0; e_full = 0; e_op = '0; e_pc = '0; e_rs1 = '0; e_rs2 = '0;
      e_imm = '0; e_rob = '0;
      return;
    end
    if (!rs_if.rdy) return;
    if (rs_if.ROB_clear) begin
      foreach (m_ent[i]) m_ent[i].used = 0;
      e_valid = 0; e_full = 0;
      return;
    end
    foreach (m_ent[i]) begin
      if (r < 0 && m_ent[i].used && !m_ent[i].jb && !m_ent[i].kb) r = i;
      if (f < 0 && !m_ent[i].used) f = i;
    end
    e_valid = (r >= 0);
    if (r >= 0) begin
      e_op = m_ent[r].op; e_pc = m_ent[r].pc; e_rs1 = m_ent[r].vj; e_rs2 = m_ent[r].vk;
      e_imm = m_ent[r].imm; e_rob = m_ent[r].rob;
      m_ent[r].used = 0;
    end
    foreach (m_ent[i]) begin
      if (m_ent[i].used) begin
        snoop(m_ent[i].jb, m_ent[i].qj, m_ent[i].vj);
        snoop(m_ent[i].kb, m_ent[i].qk, m_ent[i].vk);
      end
    end
    if (rs_if.ID_input_valid && !e_full && f >= 0) begin
      ne.used = 1; ne.op = rs_if.ID_OP_ID; ne.pc = rs_if.ID_inst_pc;
      ne.vj = rs_if.ID_Vj; ne.vk = rs_if.ID_Vk; ne.imm = rs_if.ID_imm;
      ne.jb = rs_if.ID_Qj_busy; ne.kb = rs_if.ID_Qk_busy;
      ne.qj = rs_if.ID_Qj; ne.qk = rs_if.ID_Qk; ne.rob = rs_if.ID_ROB_id;
`ifdef RS_DISPATCH_FWD_EN
      snoop(ne.jb, ne.qj, ne.vj);
      snoop(ne.kb, ne.qk, ne.vk);
`endif
      m_ent[f] = ne;
    end
    foreach (m_ent[i]) if (m_ent[i].used) n++;
    e_full = (n >= Depth - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("valid", rs_if.ALU_output_valid, e_valid);
    check_eq("full",  rs_if.RS_full,          e_full);
    check_eq("op",    rs_if.ALU_OP_ID,        e_op);
    check_eq("pc",    rs_if.ALU_inst_pc,      e_pc);
    check_eq("rs1",   rs_if.ALU_reg_rs1,      e_rs1);
    check_eq("rs2",   rs_if.ALU_reg_rs2,      e_rs2);
    check_eq("imm",   rs_if.ALU_imm,          e_imm);
    check_eq("rob",   rs_if.ALU_ROB_id,       e_rob);
  endtask

  task automatic idle();
    rst = 0;
    rs_if.rdy = 1; rs_if.ROB_clear = 0; rs_if.ID_input_valid = 0;
    rs_if.ALU_cdb_valid = 0; rs_if.LSB_cdb_valid = 0;
  endtask

  task automatic disp(input op_id_t op, input data_t pc, input data_t vj, input bit qjb,
                      input rob_id_t qj, input data_t vk, input bit qkb, input rob_id_t qk,
                      input data_t imm, input rob_id_t rob);
    rs_if.ID_input_valid = 1; rs_if.ID_OP_ID = op; rs_if.ID_inst_pc = pc;
    rs_if.ID_Vj = vj; rs_if.ID_Qj_busy = qjb; rs_if.ID_Qj = qj;
    rs_if.ID_Vk = vk; rs_if.ID_Qk_busy = qkb; rs_if.ID_Qk = qk;
    rs_if.ID_imm = imm; rs_if.ID_ROB_id = rob;
  endtask

  task automatic flush();
    idle(); rs_if.ROB_clear = 1; tick(); idle();
  endtask

  initial begin
    idle();
    rst = 1;
    disp(OpNop, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rs_if.ID_input_valid = 0;
    rs_if.ALU_cdb_ROB_id = 0; rs_if.ALU_cdb_value = 0;
    rs_if.LSB_cdb_ROB_id = 0; rs_if.LSB_cdb_value = 0;
    tick(); tick();
    check_eq("rst_valid", rs_if.ALU_output_valid, 0);
    check_eq("rst_full",  rs_if.RS_full, 0);
    idle();

    // ADDI with ready operands issues one cycle after dispatch.
    disp(OpAddi, 32'h100, 5, 0, 0, 0, 0, 0, 7, 3);
    tick(); idle();
    check_eq("t1_not_yet", rs_if.ALU_output_valid, 0);
    tick();
    check_eq("t1_valid", rs_if.ALU_output_valid, 1);
    check_eq("t1_rs1",   rs_if.ALU_reg_rs1, 5);
    check_eq("t1_imm",   rs_if.ALU_imm, 7);
    check_eq("t1_rob",   rs_if.ALU_ROB_id, 3);
    tick();
    check_eq("t1_drop", rs_if.ALU_output_valid, 0);

    // Pending Qj woken by the load bus.
    disp(OpAdd, 32'h104, 0, 1, 2, 1, 0, 0, 0, 5);
    tick(); idle(); tick();
    rs_if.LSB_cdb_valid = 1; rs_if.LSB_cdb_ROB_id = 2; rs_if.LSB_cdb_value = 32'h10;
    tick(); idle();
    check_eq("t2_wake_edge", rs_if.ALU_output_valid, 0);
    tick();
    check_eq("t2_valid", rs_if.ALU_output_valid, 1);
    check_eq("t2_rs1",   rs_if.ALU_reg_rs1, 32'h10);
    check_eq("t2_rob",   rs_if.ALU_ROB_id, 5);
    tick();

    // Fill 15 pending entries, dispatch while full is ignored, one wakeup frees space.
    for (int i = 0; i < 15; i++) begin
      disp(OpAdd, 32'(i * 4), 0, 1, rob_id_t'(i), 0, 0, 0, 0, rob_id_t'(i));
      tick();
    end
    idle();
    check_eq("t3_full", rs_if.RS_full, 1);
    disp(OpAddi, 32'h200, 1, 0, 0, 0, 0, 0, 1, 15);
    tick(); idle(); tick();
    check_eq("t3_ignored", rs_if.ALU_output_valid, 0);
    check_eq("t3_still_full", rs_if.RS_full, 1);
    rs_if.ALU_cdb_valid = 1; rs_if.ALU_cdb_ROB_id = 3; rs_if.ALU_cdb_value = 32'h33;
    tick(); idle(); tick();
    check_eq("t3_issue", rs_if.ALU_output_valid, 1);
    check_eq("t3_rob",   rs_if.ALU_ROB_id, 3);
    check_eq("t3_rs1",   rs_if.ALU_reg_rs1, 32'h33);
    check_eq("t3_unfull", rs_if.RS_full, 0);
    flush();

    // Slots 0,2,5 wake together and issue in index order.
    for (int i = 0; i < 6; i++) begin
      disp(OpSub, 32'h300, 0, 1, (i == 0 || i == 2 || i == 5) ? 4'd8 : 4'd9, 0, 0, 0, 0,
           rob_id_t'(i));
      tick();
    end
    idle();
    rs_if.ALU_cdb_valid = 1; rs_if.ALU_cdb_ROB_id = 8; rs_if.ALU_cdb_value = 32'h80;
    tick(); idle();
    tick(); check_eq("t4_first",  rs_if.ALU_ROB_id, 0);
    tick(); check_eq("t4_second", rs_if.ALU_ROB_id, 2);
    tick(); check_eq("t4_third",  rs_if.ALU_ROB_id, 5);
    check_eq("t4_third_v", rs_if.ALU_output_valid, 1);
    tick(); check_eq("t4_done", rs_if.ALU_output_valid, 0);

    // Flush with six busy entries and a same-cycle dispatch.
    for (int i = 0; i < 3; i++) begin
      disp(OpSub, 32'h400, 0, 1, 10, 0, 0, 0, 0, rob_id_t'(10 + i));
      tick();
    end
    disp(OpAddi, 32'h500, 1, 0, 0, 0, 0, 0, 1, 7);
    rs_if.ROB_clear = 1;
    tick(); idle();
    check_eq("t5_valid", rs_if.ALU_output_valid, 0);
    check_eq("t5_full",  rs_if.RS_full, 0);
    tick();
    check_eq("t5_dropped", rs_if.ALU_output_valid, 0);

    // BEQ dispatched on the same edge as its producer's broadcast.
    disp(OpBeq, 32'h600, 0, 1, 4, 9, 0, 0, 0, 6);
    rs_if.ALU_cdb_valid = 1; rs_if.ALU_cdb_ROB_id = 4; rs_if.ALU_cdb_value = 9;
    tick(); idle(); tick();
`ifdef RS_DISPATCH_FWD_EN
    check_eq("t6_fwd_valid", rs_if.ALU_output_valid, 1);
    check_eq("t6_fwd_rs1",   rs_if.ALU_reg_rs1, 9);
`else
    check_eq("t6_lost", rs_if.ALU_output_valid, 0);
    tick();
    check_eq("t6_lost2", rs_if.ALU_output_valid, 0);
`endif
    flush();

    // Random traffic, including rdy stalls, flushes and one mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 1500);
      rs_if.rdy = ($urandom_range(0, 9) != 0);
      rs_if.ROB_clear = ($urandom_range(0, 79) == 0);
      disp(op_id_t'($urandom_range(0, 63)), $urandom(), $urandom(), 1'($urandom_range(0, 1)),
           rob_id_t'($urandom_range(0, 15)), $urandom(), 1'($urandom_range(0, 1)),
           rob_id_t'($urandom_range(0, 15)), $urandom(), rob_id_t'($urandom_range(0, 15)));
      rs_if.ID_input_valid = 1'($urandom_range(0, 1));
      rs_if.ALU_cdb_valid = 1'($urandom_range(0, 1));
      rs_if.ALU_cdb_ROB_id = rob_id_t'($urandom_range(0, 15));
      rs_if.ALU_cdb_value = $urandom();
      rs_if.LSB_cdb_valid = 1'($urandom_range(0, 1));
      rs_if.LSB_cdb_ROB_id = rob_id_t'($urandom_range(0, 15));
      rs_if.LSB_cdb_value = $urandom();
      if (rs_if.ALU_cdb_valid && rs_if.LSB_cdb_valid &&
          rs_if.ALU_cdb_ROB_id == rs_if.LSB_cdb_ROB_id) begin
        rs_if.LSB_cdb_ROB_id = rs_if.LSB_cdb_ROB_id ^ 4'd1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
